// File: rtl/dmem_bus_bridge_pkg.sv
// Purpose : shared access codes, bridge FSM states and the posted-write entry type.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package dmem_bus_bridge_pkg;

    // Access codes presented by EX/MEM on dmem_ctl.
    localparam logic [3:0] DMEM_NOP = 4'd0;
    localparam logic [3:0] DMEM_LW  = 4'd1;
    localparam logic [3:0] DMEM_LHS = 4'd2;
    localparam logic [3:0] DMEM_LHU = 4'd3;
    localparam logic [3:0] DMEM_LBS = 4'd4;
    localparam logic [3:0] DMEM_LBU = 4'd5;
    localparam logic [3:0] DMEM_SW  = 4'd6;
    localparam logic [3:0] DMEM_SH  = 4'd7;
    localparam logic [3:0] DMEM_SB  = 4'd8;

    typedef enum logic [2:0] {
        DBB_IDLE       = 3'd0,
        DBB_WR_BUSY    = 3'd1,
        DBB_RD_WAIT_WR = 3'd2,
        DBB_RD_BUSY    = 3'd3,
        DBB_RD_DONE    = 3'd4
    } dbb_state_t;

    // One posted write: word address, store data, byte enables (bit3 = byte 0).
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_ent_t;

    function automatic logic is_load(input logic [3:0] ctl);
        return (ctl == DMEM_LW)  || (ctl == DMEM_LHS) || (ctl == DMEM_LHU) ||
               (ctl == DMEM_LBS) || (ctl == DMEM_LBU);
    endfunction

endpackage

// File: rtl/dmem_bus_bridge_wbuf.sv
// Purpose : one-entry posted-write buffer (dmem_wbuf) holding the write currently on the bus.
// Latency : entry visible on ent/vld the cycle after load.
// Backpressure: none; the owner only loads when the entry is free.
// Ports: clk, rst_n; load/clear controls; din entry in; vld flag and ent entry out.
module dmem_wbuf
    import dmem_bus_bridge_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    load,
    input  logic    clear,
    input  wr_ent_t din,
    output logic    vld,
    output wr_ent_t ent
);

    // Clear only drops the valid flag so the bus fields stay stable after completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            ent <= '0;
        end else if (load) begin
            vld <= 1'b1;
            ent <= din;
        end else if (clear) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/dmem_bus_bridge.sv
// Purpose : bridges the memory stage's single-cycle RAM port onto the req/ack data bus.
// Latency : posted writes cost no stall; reads stall from presentation until the ack edge,
//           with zZ_din valid in the first unstalled cycle.
// Backpressure: stall holds the pipeline while a read is outstanding or a second access
//           arrives behind a busy write; bus_req is held until bus_ack or timeout.
// Ports: stage side dmem_ctl/Zz_addr/Zz_dout/Zz_wr_en in, zZ_din/stall out;
//        bus side bus_req/bus_we/bus_addr/bus_wdata/bus_be/bus_err out, bus_ack/bus_rdata in.
module dmem_bus_bridge
    import dmem_bus_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [31:0] RD_ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  dmem_ctl,
    input  logic [31:0] Zz_addr,
    input  logic [31:0] Zz_dout,
    input  logic [3:0]  Zz_wr_en,
    output logic [31:0] zZ_din,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    dbb_state_t  state, state_nxt;
    logic [7:0]  tmo_cnt;
    logic [31:0] rd_addr;
    logic [3:0]  rd_be;
    logic [31:0] word_addr;
    wr_ent_t     wb_din, wb_ent;
    logic        wb_vld;
    logic        is_wr, rd_req;
    logic        ack_hit, tmo_hit, txn_end;
    logic        issue_wr, issue_rd, stall_c;

    assign word_addr = Zz_addr & 32'hFFFF_FFFC;
    assign is_wr     = |Zz_wr_en;
    // Upper half of the address space is I/O: such loads never touch the bus.
    assign rd_req    = !is_wr && is_load(dmem_ctl) && !Zz_addr[31];

    // An ack arriving on the timeout cycle completes the transfer normally.
    assign ack_hit = bus_req && bus_ack;
    assign tmo_hit = bus_req && !bus_ack && (tmo_cnt == TMO_LAST);
    assign txn_end = ack_hit || tmo_hit;

    assign wb_din = {word_addr, Zz_dout, Zz_wr_en};

    dmem_wbuf u_wbuf (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (issue_wr),
        .clear (txn_end && bus_we),
        .din   (wb_din),
        .vld   (wb_vld),
        .ent   (wb_ent)
    );

    assign bus_addr  = bus_we ? wb_ent.addr : rd_addr;
    assign bus_be    = bus_we ? wb_ent.be   : rd_be;
    assign bus_wdata = wb_ent.data;

    // Stall is forced low in reset so a load still presented cannot hold the pipe.
    assign stall = rst_n && stall_c;

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        issue_wr  = 1'b0;
        issue_rd  = 1'b0;
        case (state)
            DBB_IDLE: begin
                if (is_wr) begin
                    issue_wr  = 1'b1;
                    state_nxt = DBB_WR_BUSY;
                end else if (rd_req) begin
                    stall_c   = 1'b1;
                    issue_rd  = 1'b1;
                    state_nxt = DBB_RD_BUSY;
                end
            end
            DBB_WR_BUSY: begin
                // A second access waits; it is taken from IDLE once the buffer drains.
                if ((is_wr && wb_vld) || rd_req) stall_c = 1'b1;
                if (txn_end)     state_nxt = DBB_IDLE;
                else if (rd_req) state_nxt = DBB_RD_WAIT_WR;
            end
            DBB_RD_WAIT_WR: begin
                stall_c = 1'b1;
                if (txn_end) state_nxt = DBB_IDLE;
            end
            DBB_RD_BUSY: begin
                stall_c = 1'b1;
                if (txn_end) state_nxt = DBB_RD_DONE;
            end
            DBB_RD_DONE: begin
                // The finished load is still presented here; it must not be reissued.
                state_nxt = DBB_IDLE;
            end
            default: state_nxt = DBB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= DBB_IDLE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            rd_addr <= '0;
            rd_be   <= '0;
            tmo_cnt <= '0;
            bus_err <= 1'b0;
            zZ_din  <= '0;
        end else begin
            state   <= state_nxt;
            bus_err <= 1'b0;
            if (issue_wr) begin
                bus_req <= 1'b1;
                bus_we  <= 1'b1;
                tmo_cnt <= '0;
            end else if (issue_rd) begin
                bus_req <= 1'b1;
                bus_we  <= 1'b0;
                rd_addr <= word_addr;
                rd_be   <= 4'hF;
                tmo_cnt <= '0;
            end else if (bus_req) begin
                if (txn_end) bus_req <= 1'b0;
                if (tmo_hit) bus_err <= 1'b1;
                if (!bus_ack) tmo_cnt <= tmo_cnt + 8'd1;
                if (state == DBB_RD_BUSY) begin
                    if (ack_hit)      zZ_din <= bus_rdata;
                    else if (tmo_hit) zZ_din <= RD_ERR_DATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Bench for dmem_bus_bridge with a short bus timeout; stage-side memory model versus bus-side slave memory.
module tb_dmem_bus_bridge;
    import dmem_bus_bridge_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  dmem_ctl;
    logic [31:0] Zz_addr, Zz_dout;
    logic [3:0]  Zz_wr_en;
    logic [31:0] zZ_din;
    logic        stall, bus_req, bus_we, bus_err;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int tests = 0;
    int fails = 0;

    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] slave_mem [logic [31:0]];

    dmem_bus_bridge #(.TIMEOUT(TMO), .RD_ERR_DATA(32'hFFFF_FFFF)) dut (
        .clk(clk), .rst_n(rst_n), .dmem_ctl(dmem_ctl), .Zz_addr(Zz_addr), .Zz_dout(Zz_dout),
        .Zz_wr_en(Zz_wr_en), .zZ_din(zZ_din), .stall(stall), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic present(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        dmem_ctl = ctl; Zz_addr = a; Zz_dout = d; Zz_wr_en = we;
    endtask

    task automatic present_nop();
        present(DMEM_NOP, 32'h0, 32'h0, 4'h0);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [3:0] pick_load(input int i);
        case (i)
            0: return DMEM_LW;
            1: return DMEM_LHS;
            2: return DMEM_LHU;
            3: return DMEM_LBS;
            default: return DMEM_LBU;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
        present(DMEM_LW, 32'h0000_0010, 32'h0, 4'h0);
        next_cycle(); next_cycle();
        settle();
        tests++; if (bus_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", bus_req); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
        tests++; if (zZ_din !== 32'h0) begin fails++; $display("FAIL reset_din: got %h want 0", zZ_din); end
        tests++; if ({bus_we, bus_err, bus_be} !== 6'h0) begin fails++; $display("FAIL reset_ctl: got we=%b err=%b be=%b want 0", bus_we, bus_err, bus_be); end
        tests++; if ({bus_addr, bus_wdata} !== 64'h0) begin fails++; $display("FAIL reset_addr_data: got %h/%h want 0", bus_addr, bus_wdata); end
        next_cycle();
        present_nop();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_posted_write();
        logic [31:0] a, d;
        int k, rc, stall_seen;
        bit done;
        for (int it = 0; it < 3; it++) begin
            a = (it == 0) ? 32'h100 : ($urandom & 32'h7FFF_FFFC);
            d = (it == 0) ? 32'h1234_5678 : $urandom;
            k = (it == 0) ? 3 : int'($urandom_range(1, 6));
            present(DMEM_SW, a, d, 4'hF);
            settle();
            stall_seen = (stall !== 1'b0) ? 1 : 0;
            next_cycle();
            present_nop();
            rc = 0; done = 0;
            for (int c = 0; c < 40 && !done; c++) begin
                if (bus_req) rc++;
                bus_ack = bus_req && (rc == k);
                settle();
                if (stall !== 1'b0) stall_seen++;
                if (bus_req && rc == 1) begin
                    tests++; if ({bus_we, bus_addr, bus_wdata, bus_be} !== {1'b1, a, d, 4'hF}) begin fails++; $display("FAIL wr_fields: got we=%b a=%h d=%h be=%b want 1 %h %h 1111", bus_we, bus_addr, bus_wdata, bus_be, a, d); end
                end
                if (!bus_req && rc > 0) done = 1;
                next_cycle();
                bus_ack = 1'b0;
            end
            tests++; if (!done) begin fails++; $display("FAIL wr_complete: got no completion want done"); end
            tests++; if (rc !== k) begin fails++; $display("FAIL wr_req_cycles: got %0d want %0d", rc, k); end
            tests++; if (stall_seen !== 0) begin fails++; $display("FAIL wr_no_stall: got %0d stalled cycles want 0", stall_seen); end
        end
    endtask

    task automatic test_read_stall();
        logic [31:0] a, rd, zd;
        int k, rc, sc;
        bit done;
        for (int it = 0; it < 3; it++) begin
            a  = (it == 0) ? 32'h104 : ($urandom & 32'h7FFF_FFFF);
            rd = (it == 0) ? 32'hCAFE_F00D : $urandom;
            k  = (it == 0) ? 2 : int'($urandom_range(1, 6));
            present(pick_load(int'($urandom_range(0, 4))), a, $urandom, 4'h0);
            rc = 0; sc = 0; done = 0; zd = '0;
            for (int c = 0; c < 40 && !done; c++) begin
                if (bus_req) rc++;
                bus_ack = bus_req && (rc == k);
                bus_rdata = bus_ack ? rd : $urandom;
                settle();
                if (c == 0) begin
                    tests++; if ({stall, bus_req} !== 2'b10) begin fails++; $display("FAIL rd_first_cycle: got stall=%b req=%b want 1 0", stall, bus_req); end
                end
                if (bus_req && rc == 1) begin
                    tests++; if ({bus_we, bus_addr, bus_be} !== {1'b0, a & 32'hFFFF_FFFC, 4'hF}) begin fails++; $display("FAIL rd_fields: got we=%b a=%h be=%b want 0 %h 1111", bus_we, bus_addr, bus_be, a & 32'hFFFF_FFFC); end
                end
                if (stall) sc++;
                else begin done = 1; zd = zZ_din; end
                next_cycle();
                bus_ack = 1'b0;
            end
            tests++; if (!done) begin fails++; $display("FAIL rd_release: got stall stuck want release"); end
            tests++; if (sc !== k + 1) begin fails++; $display("FAIL rd_stall_len: got %0d want %0d", sc, k + 1); end
            tests++; if (zd !== rd) begin fails++; $display("FAIL rd_data: got %h want %h", zd, rd); end
            present_nop();
            settle();
            tests++; if (bus_req !== 1'b0) begin fails++; $display("FAIL rd_no_reissue: got req=%b want 0", bus_req); end
            tests++; if (zZ_din !== rd) begin fails++; $display("FAIL rd_hold: got %h want %h", zZ_din, rd); end
            next_cycle();
        end
    endtask

    task automatic test_write_then_read();
        logic [31:0] la [4];
        logic [31:0] ld [4];
        logic [3:0]  lb [4];
        logic        lw [4];
        logic [31:0] rd, zd;
        int kw, kr, cur, ntx;
        bit prev, done;
        rd = $urandom; kw = int'($urandom_range(1, 4)); kr = int'($urandom_range(1, 4));
        present(DMEM_SB, 32'h101, {4{8'hAB}}, 4'b0100);
        settle();
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL wr_rd_post: got stall=%b want 0", stall); end
        next_cycle();
        present(DMEM_LW, 32'h104, 32'h0, 4'h0);
        ntx = 0; cur = 0; prev = 0; done = 0; zd = '0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (bus_req && !prev) begin
                if (ntx < 4) begin la[ntx] = bus_addr; ld[ntx] = bus_wdata; lb[ntx] = bus_be; lw[ntx] = bus_we; end
                ntx++; cur = 0;
            end
            prev = bus_req;
            if (bus_req) cur++;
            bus_ack = bus_req && (cur == ((ntx == 1) ? kw : kr));
            bus_rdata = rd;
            settle();
            if (c == 0) begin
                tests++; if (stall !== 1'b1) begin fails++; $display("FAIL wr_rd_hold: got stall=%b want 1", stall); end
            end
            if (!stall) begin done = 1; zd = zZ_din; end
            next_cycle();
            bus_ack = 1'b0;
        end
        present_nop();
        tests++; if (!done || ntx !== 2) begin fails++; $display("FAIL wr_rd_count: got done=%b txns=%0d want 1 2", done, ntx); end
        if (ntx >= 2) begin
            tests++; if ({lw[0], la[0], lb[0], ld[0]} !== {1'b1, 32'h100, 4'b0100, {4{8'hAB}}}) begin fails++; $display("FAIL wr_rd_first: got we=%b a=%h be=%b d=%h want W 100 0100 abababab", lw[0], la[0], lb[0], ld[0]); end
            tests++; if ({lw[1], la[1], lb[1]} !== {1'b0, 32'h104, 4'hF}) begin fails++; $display("FAIL wr_rd_second: got we=%b a=%h be=%b want R 104 1111", lw[1], la[1], lb[1]); end
        end
        tests++; if (zd !== rd) begin fails++; $display("FAIL wr_rd_data: got %h want %h", zd, rd); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] la [4];
        logic [31:0] ld [4];
        logic [31:0] d1, d2;
        int cur, ntx;
        bit prev, done, accepted;
        d1 = $urandom; d2 = $urandom;
        present(DMEM_SW, 32'h180, d1, 4'hF);
        next_cycle();
        present(DMEM_SW, 32'h184, d2, 4'hF);
        ntx = 0; cur = 0; prev = 0; done = 0; accepted = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (accepted) present_nop();
            if (bus_req && !prev) begin
                if (ntx < 4) begin la[ntx] = bus_addr; ld[ntx] = bus_wdata; end
                ntx++; cur = 0;
            end
            prev = bus_req;
            if (bus_req) cur++;
            bus_ack = bus_req && (cur == 2);
            settle();
            if (c == 0) begin
                tests++; if (stall !== 1'b1) begin fails++; $display("FAIL b2b_stall: got %b want 1", stall); end
            end
            if (!accepted && !stall) accepted = 1;
            if (ntx == 2 && !bus_req) done = 1;
            next_cycle();
            bus_ack = 1'b0;
        end
        present_nop();
        tests++; if (!done || ntx !== 2) begin fails++; $display("FAIL b2b_count: got done=%b txns=%0d want 1 2", done, ntx); end
        if (ntx >= 2) begin
            tests++; if ({la[0], ld[0], la[1], ld[1]} !== {32'h180, d1, 32'h184, d2}) begin fails++; $display("FAIL b2b_order: got %h:%h %h:%h want 180:%h 184:%h", la[0], ld[0], la[1], ld[1], d1, d2); end
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        logic [31:0] rd, zd;
        int rc, errs, err_c, last_c, sc;
        bit done;
        for (int s = 0; s < 3; s++) begin
            rd = 32'h600D_BEEF;
            if (s == 1) present(DMEM_SW, 32'h204, $urandom, 4'hF);
            else        present(DMEM_LW, 32'h200, 32'h0, 4'h0);
            rc = 0; errs = 0; err_c = -1; last_c = -1; sc = 0; done = 0; zd = '0;
            for (int c = 0; c < 20; c++) begin
                if (done || (s == 1 && c > 0)) present_nop();
                if (bus_req) rc++;
                bus_ack = (s == 2) && bus_req && (rc == TMO);
                bus_rdata = bus_ack ? rd : $urandom;
                settle();
                if (bus_err) begin errs++; err_c = c; end
                if (bus_req) last_c = c;
                if (stall) sc++;
                if (s != 1 && !stall && !done) begin done = 1; zd = zZ_din; end
                next_cycle();
                bus_ack = 1'b0;
            end
            tests++; if (rc !== TMO) begin fails++; $display("FAIL tmo_req_cycles s%0d: got %0d want %0d", s, rc, TMO); end
            tests++; if (errs !== ((s == 2) ? 0 : 1)) begin fails++; $display("FAIL tmo_err_count s%0d: got %0d want %0d", s, errs, (s == 2) ? 0 : 1); end
            if (s != 2) begin
                tests++; if (err_c !== last_c + 1) begin fails++; $display("FAIL tmo_err_when s%0d: got cycle %0d want %0d", s, err_c, last_c + 1); end
            end
            if (s == 1) begin
                tests++; if (sc !== 0) begin fails++; $display("FAIL tmo_wr_stall: got %0d want 0", sc); end
            end else begin
                tests++; if (!done || zd !== ((s == 0) ? 32'hFFFF_FFFF : rd)) begin fails++; $display("FAIL tmo_rd_data s%0d: got %h want %h", s, zd, (s == 0) ? 32'hFFFF_FFFF : rd); end
            end
        end
    endtask

    task automatic test_io_read();
        int bad;
        bad = 0;
        present(DMEM_LW, 32'h8000_0000, 32'h0, 4'h0);
        for (int c = 0; c < 6; c++) begin
            if (c == 3) present(DMEM_LBU, 32'h8000_0000 | ($urandom & 32'h7FFF_FFFF), 32'h0, 4'h0);
            settle();
            if (stall !== 1'b0 || bus_req !== 1'b0) bad++;
            next_cycle();
        end
        present_nop();
        tests++; if (bad !== 0) begin fails++; $display("FAIL io_read: got %0d cycles with stall or req want 0", bad); end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] rd, zd;
        int rc, sc;
        bit done;
        present(DMEM_LW, 32'h300, 32'h0, 4'h0);
        next_cycle(); next_cycle();
        tests++; if (bus_req !== 1'b1) begin fails++; $display("FAIL rst_pre_req: got %b want 1", bus_req); end
        rst_n = 1'b0;
        settle();
        tests++; if ({bus_req, stall, bus_err} !== 3'b000) begin fails++; $display("FAIL rst_mid_ctl: got req=%b stall=%b err=%b want 000", bus_req, stall, bus_err); end
        tests++; if (zZ_din !== 32'h0) begin fails++; $display("FAIL rst_mid_din: got %h want 0", zZ_din); end
        next_cycle();
        rst_n = 1'b1;
        rd = $urandom; rc = 0; sc = 0; done = 0; zd = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (bus_req) rc++;
            bus_ack = bus_req && (rc == 1);
            bus_rdata = bus_ack ? rd : $urandom;
            settle();
            if (stall) sc++;
            else begin done = 1; zd = zZ_din; end
            next_cycle();
            bus_ack = 1'b0;
        end
        present_nop();
        tests++; if (!done || sc !== 2 || zd !== rd) begin fails++; $display("FAIL rst_post_read: got done=%b stall=%0d data=%h want 1 2 %h", done, sc, zd, rd); end
        next_cycle();
    endtask

    task automatic test_random_traffic();
        logic [31:0] a, w, d, wa, mw, sw, zd;
        logic [3:0]  be, ctl;
        int k, rc, sc, sz;
        bit done, wr;
        for (int n = 0; n < 30; n++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 32'h400 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            w  = $urandom;
            k  = int'($urandom_range(1, 5));
            wa = a & 32'hFFFF_FFFC;
            rc = 0; sc = 0; done = 0; zd = '0;
            if (wr) begin
                sz = int'($urandom_range(0, 2));
                if (sz == 0) begin ctl = DMEM_SB; be = 4'b1000 >> a[1:0]; d = {4{w[7:0]}}; end
                else if (sz == 1) begin a[0] = 1'b0; ctl = DMEM_SH; be = a[1] ? 4'b0011 : 4'b1100; d = {2{w[15:0]}}; end
                else begin a[1:0] = 2'b00; ctl = DMEM_SW; be = 4'hF; d = w; end
                mw = model_mem.exists(wa) ? model_mem[wa] : init_word(wa);
                for (int i = 0; i < 4; i++) if (be[3-i]) mw[31-8*i -: 8] = d[31-8*i -: 8];
                model_mem[wa] = mw;
                present(ctl, a, d, be);
                for (int c = 0; c < 40 && !done; c++) begin
                    if (c == 1) present_nop();
                    if (bus_req) rc++;
                    bus_ack = bus_req && (rc == k);
                    settle();
                    if (stall) sc++;
                    if (bus_ack) begin
                        sw = slave_mem.exists(bus_addr) ? slave_mem[bus_addr] : init_word(bus_addr);
                        for (int i = 0; i < 4; i++) if (bus_be[3-i]) sw[31-8*i -: 8] = bus_wdata[31-8*i -: 8];
                        slave_mem[bus_addr] = sw;
                        tests++; if ({bus_we, bus_addr} !== {1'b1, wa}) begin fails++; $display("FAIL rnd_wr_addr: got we=%b a=%h want 1 %h", bus_we, bus_addr, wa); end
                    end
                    if (!bus_req && rc > 0) done = 1;
                    next_cycle();
                    bus_ack = 1'b0;
                end
                tests++; if (!done || sc !== 0) begin fails++; $display("FAIL rnd_wr_flow: got done=%b stall=%0d want 1 0", done, sc); end
            end else begin
                present(pick_load(int'($urandom_range(0, 4))), a, $urandom, 4'h0);
                for (int c = 0; c < 40 && !done; c++) begin
                    if (bus_req) rc++;
                    bus_ack = bus_req && (rc == k);
                    bus_rdata = !bus_ack ? $urandom : (slave_mem.exists(bus_addr) ? slave_mem[bus_addr] : init_word(bus_addr));
                    settle();
                    if (stall) sc++;
                    else begin done = 1; zd = zZ_din; end
                    next_cycle();
                    bus_ack = 1'b0;
                end
                mw = model_mem.exists(wa) ? model_mem[wa] : init_word(wa);
                tests++; if (!done || sc !== k + 1) begin fails++; $display("FAIL rnd_rd_stall: got done=%b stall=%0d want 1 %0d", done, sc, k + 1); end
                tests++; if (zd !== mw) begin fails++; $display("FAIL rnd_rd_data @%h: got %h want %h", wa, zd, mw); end
            end
            present_nop();
        end
        next_cycle();
    endtask

    initial begin
        present_nop();
        test_reset();
        test_posted_write();
        test_read_stall();
        test_write_then_read();
        test_back_to_back();
        test_timeout();
        test_io_read();
        test_reset_mid_read();
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
